// File: rtl/track_line_gen.sv
// Per-scanline road geometry generator for the pseudo-3D track renderer.
// Computes the next line's packed track word during horizontal blanking.
module track_line_gen #(
   parameter int HORIZON      = 240,
   parameter int ROAD_W       = 320,
   parameter int DEPTH_K      = 8192,
   parameter int STRIPE_SHIFT = 4
) (
   input  logic               pixel_clk,
   input  logic               Reset,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   input  logic [15:0]        position,
   input  logic signed [7:0]  curvature,
   input  logic signed [9:0]  player_x,
   output logic [31:0]        track,
   output logic               isTrack
);

   typedef enum logic [1:0] {IDLE, DIV, COMBINE, DONE} state_t;

   localparam logic [9:0] HZ = 10'(HORIZON);

   state_t             state_q, state_d;
   logic [15:0]        pos_q;
   logic signed [7:0]  curve_q;
   logic signed [9:0]  px_q;
   logic [7:0]         d_q, d_d;
   logic [15:0]        dvd_q, dvd_d;
   logic [7:0]         rem_q, rem_d;
   logic [15:0]        quo_q, quo_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [31:0]        res_q, res_d;
   logic               rtrk_q, rtrk_d;
   logic [31:0]        track_q, track_d;
   logic               istrk_q, istrk_d;

   logic [9:0]         ny;
   logic               trk_line;
   logic [8:0]         rem_sh;
   logic [31:0]        rw_prod;
   logic [9:0]         rw, clip, midp;
   logic [7:0]         k;
   logic signed [8:0]  ks;
   logic signed [24:0] cprod;
   logic signed [19:0] pprod;
   logic signed [12:0] mid;
   logic               stripe;

   assign ny       = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
   assign trk_line = (ny >= HZ) && (ny <= 10'd479);
   assign rem_sh   = {rem_q, dvd_q[15]};

   // Line geometry from the latched depth and frame parameters
   always_comb begin
      rw_prod = 32'(ROAD_W) * {24'd0, d_q};
      rw      = 10'(rw_prod >> 8);
      clip    = rw >> 3;
      k       = 8'd240 - d_q;
      ks      = $signed({1'b0, k});
      cprod   = curve_q * ks * ks;
      pprod   = px_q * $signed({1'b0, d_q});
      mid     = 13'sd320 + 13'(cprod >>> 14) - 13'(pprod >>> 8);
      if (mid < 13'sd0)
         midp = 10'd0;
      else if (mid > 13'sd1023)
         midp = 10'd1023;
      else
         midp = mid[9:0];
      stripe  = 1'((quo_q + pos_q) >> STRIPE_SHIFT);
   end

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      rtrk_d  = rtrk_q;
      track_d = track_q;
      istrk_d = istrk_q;
      if (DrawX == 10'd799) begin
         state_d = IDLE;
         track_d = (state_q == DONE) ? res_q : 32'd0;
         istrk_d = (state_q == DONE) ? rtrk_q : 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (DrawX == 10'd640) begin
                  if (trk_line) begin
                     state_d = DIV;
                     d_d     = 8'(ny - HZ + 10'd1);
                     dvd_d   = 16'(DEPTH_K);
                     rem_d   = 8'd0;
                     quo_d   = 16'd0;
                     cnt_d   = 4'd0;
                  end else begin
                     state_d = DONE;
                     res_d   = 32'd0;
                     rtrk_d  = 1'b0;
                  end
               end
            end
            DIV: begin
               if (rem_sh >= {1'b0, d_q}) begin
                  rem_d = 8'(rem_sh - {1'b0, d_q});
                  quo_d = {quo_q[14:0], 1'b1};
               end else begin
                  rem_d = rem_sh[7:0];
                  quo_d = {quo_q[14:0], 1'b0};
               end
               dvd_d = {dvd_q[14:0], 1'b0};
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15)
                  state_d = COMBINE;
            end
            COMBINE: begin
               res_d   = {stripe, 1'b0, midp, rw, clip};
               rtrk_d  = 1'b1;
               state_d = DONE;
            end
            DONE: begin
            end
         endcase
      end
   end

   always_ff @(posedge pixel_clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         d_q     <= '0;
         dvd_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         rtrk_q  <= 1'b0;
         track_q <= '0;
         istrk_q <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         rtrk_q  <= rtrk_d;
         track_q <= track_d;
         istrk_q <= istrk_d;
      end
   end

   // Frame parameters are sampled once, at the last pixel of the frame
   always_ff @(posedge pixel_clk or posedge Reset) begin
      if (Reset) begin
         pos_q   <= '0;
         curve_q <= '0;
         px_q    <= '0;
      end else if (DrawY == 10'd524 && DrawX == 10'd799) begin
         pos_q   <= position;
         curve_q <= curvature;
         px_q    <= player_x;
      end
   end

   assign track   = track_q;
   assign isTrack = istrk_q;

endmodule
